// File: rtl/fifo_pack.sv
// Drains up to eight per-channel byte FIFOs into one framed packet:
// HEAD0 HEAD1 info kind smpr | SEG_LEN bytes per enabled channel | checksum | trailer.
module fifo_pack #(
  parameter int         NUM_CH  = 8,
  parameter int         SEG_LEN = 64,
  parameter int         TIMEOUT = 1023,
  parameter logic [7:0] HEAD0   = 8'h55,
  parameter logic [7:0] HEAD1   = 8'hAA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fs_fifo,
  output logic                  fd_fifo,
  output logic                  err,
  input  logic [7:0]            dev_smpr,
  input  logic [7:0]            dev_info,
  input  logic [7:0]            dev_kind,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic [7:0]            adc_end,
  input  logic [8*NUM_CH-1:0]   fifoi_rxd,
  input  logic [NUM_CH-1:0]     fifoi_empty,
  output logic [NUM_CH-1:0]     fifoi_rxen,
  output logic                  fifod_txen,
  output logic [7:0]            fifod_txd,
  output logic [2:0]            dbg_state
);

  localparam int CW = $clog2(NUM_CH);
  localparam int IW = $clog2(SEG_LEN + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEAD = 3'd1,
    SEL  = 3'd2,
    READ = 3'd3,
    CHK  = 3'd4,
    TAIL = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        head_idx;
  logic [CW-1:0]     ch_q;
  logic [CW-1:0]     sel_ch;
  logic [NUM_CH-1:0] remain_q;
  logic [IW-1:0]     issued_q;
  logic [TW-1:0]     wait_q;
  logic              pad_q;
  logic              pipe_valid_q;
  logic              pipe_pad_q;
  logic [7:0]        chk_q;
  logic [7:0]        info_q, kind_q, smpr_q, tail_q;

  logic              seg_open;
  logic              rd_req;
  logic              pad_req;
  logic [7:0]        rx_byte;
  logic [7:0]        pipe_byte;
  logic [7:0]        head_byte;

  // Handshake: fs_fifo is a level request sampled only in IDLE; fd_fifo stays
  // high in DONE until fs_fifo drops, so a held request never restarts a packet.
  assign dbg_state = state_q;
  assign fd_fifo   = (state_q == DONE);

  assign seg_open  = (issued_q != IW'(SEG_LEN));
  assign rd_req    = (state_q == READ) && !pad_q && seg_open && !fifoi_empty[ch_q];
  assign pad_req   = (state_q == READ) && pad_q && seg_open;
  assign rx_byte   = fifoi_rxd[{ch_q, 3'b000} +: 8];
  assign pipe_byte = pipe_pad_q ? 8'h00 : rx_byte;

  always_comb begin
    fifoi_rxen = '0;
    if (rd_req) fifoi_rxen = NUM_CH'(1) << ch_q;
  end

  // Lowest remaining channel wins, giving the 0 -> 7 walk order.
  always_comb begin
    sel_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (remain_q[i]) sel_ch = CW'(i);
    end
  end

  always_comb begin
    head_byte = HEAD0;
    case (head_idx)
      3'd0:    head_byte = HEAD0;
      3'd1:    head_byte = HEAD1;
      3'd2:    head_byte = info_q;
      3'd3:    head_byte = kind_q;
      3'd4:    head_byte = smpr_q;
      default: head_byte = HEAD0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fs_fifo) state_d = HEAD;
      HEAD: if (head_idx == 3'd4) state_d = SEL;
      SEL:  state_d = (remain_q == '0) ? CHK : READ;
      READ: if (!seg_open && !pipe_valid_q) state_d = SEL;
      CHK:  state_d = TAIL;
      TAIL: state_d = DONE;
      DONE: if (!fs_fifo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_idx     <= '0;
      ch_q         <= '0;
      remain_q     <= '0;
      issued_q     <= '0;
      wait_q       <= '0;
      pad_q        <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_pad_q   <= 1'b0;
      chk_q        <= '0;
      err          <= 1'b0;
      info_q       <= '0;
      kind_q       <= '0;
      smpr_q       <= '0;
      tail_q       <= '0;
      fifod_txen   <= 1'b0;
      fifod_txd    <= '0;
    end else begin
      fifod_txen   <= 1'b0;
      // Pad bytes ride the same two-cycle pipeline as real reads so the
      // output timing is identical for data and padding.
      pipe_valid_q <= rd_req || pad_req;
      pipe_pad_q   <= pad_req;
      if (rd_req || pad_req) issued_q <= issued_q + IW'(1);

      case (state_q)
        IDLE: begin
          head_idx <= '0;
          if (fs_fifo) begin
            info_q   <= dev_info;
            kind_q   <= dev_kind;
            smpr_q   <= dev_smpr;
            tail_q   <= adc_end;
            remain_q <= ch_mask;
            chk_q    <= '0;
            err      <= 1'b0;
          end
        end
        HEAD: begin
          fifod_txen <= 1'b1;
          fifod_txd  <= head_byte;
          if (head_idx >= 3'd2) chk_q <= chk_q + head_byte;
          head_idx   <= head_idx + 3'd1;
        end
        SEL: begin
          if (remain_q != '0) begin
            ch_q             <= sel_ch;
            remain_q[sel_ch] <= 1'b0;
            issued_q         <= '0;
            wait_q           <= '0;
            pad_q            <= 1'b0;
          end
        end
        READ: begin
          if (pipe_valid_q) begin
            fifod_txen <= 1'b1;
            fifod_txd  <= pipe_byte;
            chk_q      <= chk_q + pipe_byte;
          end
          if (rd_req) begin
            wait_q <= '0;
          end else if (!pad_q && seg_open) begin
            if (wait_q == TW'(TIMEOUT)) begin
              pad_q <= 1'b1;
              err   <= 1'b1;
            end else begin
              wait_q <= wait_q + TW'(1);
            end
          end
        end
        CHK: begin
          fifod_txen <= 1'b1;
          fifod_txd  <= chk_q;
        end
        TAIL: begin
          fifod_txen <= 1'b1;
          fifod_txd  <= tail_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pack.sv
// Directed bench for fifo_pack: behavioural source FIFOs, output stream capture,
// hand-computed packets compared byte by byte.
module tb_fifo_pack;

  localparam int SEG_LEN = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_fifo;
  logic        fd_fifo;
  logic        err;
  logic [7:0]  dev_smpr, dev_info, dev_kind, ch_mask, adc_end;
  logic [63:0] fifoi_rxd = '0;
  logic [7:0]  fifoi_empty;
  logic [7:0]  fifoi_rxen;
  logic        fifod_txen;
  logic [7:0]  fifod_txd;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_pack #(.SEG_LEN(SEG_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fs_fifo(fs_fifo), .fd_fifo(fd_fifo), .err(err),
    .dev_smpr(dev_smpr), .dev_info(dev_info), .dev_kind(dev_kind),
    .ch_mask(ch_mask), .adc_end(adc_end), .fifoi_rxd(fifoi_rxd),
    .fifoi_empty(fifoi_empty), .fifoi_rxen(fifoi_rxen),
    .fifod_txen(fifod_txen), .fifod_txd(fifod_txd), .dbg_state(dbg_state)
  );

  // Source FIFO models: non-FWFT, data one edge after rxen.
  logic [7:0] mem [8][256];
  int         wp [8];
  int         rp [8];
  logic       tog_en = 1'b0;
  logic       tog = 1'b0;
  int         underflow = 0;

  always_comb begin
    for (int n = 0; n < 8; n++) fifoi_empty[n] = (wp[n] == rp[n]) || (tog_en && tog);
  end

  always @(posedge clk) begin
    tog <= ~tog;
    for (int n = 0; n < 8; n++) begin
      if (fifoi_rxen[n]) begin
        if (fifoi_empty[n]) underflow <= underflow + 1;
        else begin
          fifoi_rxd[8*n +: 8] <= mem[n][rp[n] & 255];
          rp[n] <= rp[n] + 1;
        end
      end
    end
  end

  // Output capture.
  logic [7:0] got_q[$];
  int         stamp_q[$];
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         rxen_pulses = 0;
  int         overlap = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifod_txen) begin
      got_q.push_back(fifod_txd);
      stamp_q.push_back(cyc);
    end
    if (fifoi_rxen != '0) rxen_pulses = rxen_pulses + 1;
    if ($countones(fifoi_rxen) > 1) overlap = overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int ch, input logic [7:0] base, input logic [7:0] step, input int n);
    logic [7:0] b;
    b = base;
    for (int i = 0; i < n; i++) begin
      mem[ch][wp[ch] & 255] = b;
      wp[ch] = wp[ch] + 1;
      b = b + step;
    end
  endtask

  task automatic check_stream(input string tag);
    logic [31:0] g;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
      check($sformatf("%s_byte%0d", tag, i), g, 32'(exp_q[i]));
    end
  endtask

  // Starts a packet, scrambles the live inputs to prove they were latched,
  // holds the request through DONE, then releases it.
  task automatic run_packet(input string tag);
    int n;
    got_q.delete();
    stamp_q.delete();
    @(negedge clk);
    fs_fifo = 1'b1;
    @(negedge clk);
    dev_info = 8'hFF; dev_kind = 8'hFF; dev_smpr = 8'hFF; adc_end = 8'hFF; ch_mask = 8'hFF;
    n = 0;
    while (!fd_fifo && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(fd_fifo), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, 32'(fd_fifo), 32'd1);
    fs_fifo = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_fd_low"}, 32'(fd_fifo), 32'd0);
    check({tag, "_idle"}, 32'(dbg_state), 32'd0);
    check_stream(tag);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    fs_fifo = 1'b0;
    dev_smpr = '0; dev_info = '0; dev_kind = '0; ch_mask = '0; adc_end = '0;
    repeat (3) @(negedge clk);
    check("rst_txen", 32'(fifod_txen), 32'd0);
    check("rst_txd", 32'(fifod_txd), 32'd0);
    check("rst_rxen", 32'(fifoi_rxen), 32'd0);
    check("rst_fd", 32'(fd_fifo), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single channel, basic frame
    load(0, 8'h01, 8'h01, 4);
    ch_mask = 8'h01; dev_info = 8'h10; dev_kind = 8'h20; dev_smpr = 8'h30; adc_end = 8'hEE;
    exp_q = '{8'h55, 8'hAA, 8'h10, 8'h20, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 8'h6A, 8'hEE};
    run_packet("t1");
    check("t1_err", 32'(err), 32'd0);

    // channels 0 and 7
    load(0, 8'hA0, 8'h01, 4);
    load(7, 8'hB0, 8'h01, 4);
    overlap = 0;
    ch_mask = 8'h81; dev_info = 8'h01; dev_kind = 8'h02; dev_smpr = 8'h03; adc_end = 8'h5A;
    exp_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
              8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h52, 8'h5A};
    run_packet("t2");
    check("t2_overlap", 32'(overlap), 32'd0);

    // empty mask
    rxen_pulses = 0;
    ch_mask = 8'h00; dev_info = 8'h80; dev_kind = 8'h90; dev_smpr = 8'h7F; adc_end = 8'h11;
    exp_q = '{8'h55, 8'hAA, 8'h80, 8'h90, 8'h7F, 8'h8F, 8'h11};
    run_packet("t3");
    check("t3_rxen", 32'(rxen_pulses), 32'd0);

    // starved channel pads after timeout
    load(0, 8'hC1, 8'h01, 2);
    ch_mask = 8'h01; dev_info = 8'h00; dev_kind = 8'h00; dev_smpr = 8'h00; adc_end = 8'hE1;
    exp_q = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h83, 8'hE1};
    run_packet("t4");
    check("t4_gap", (stamp_q.size() > 8) ? 32'(stamp_q[7] - stamp_q[6] - 1) : 32'hFFFF_FFFF, 32'd16);
    check("t4_pad_spacing", (stamp_q.size() > 8) ? 32'(stamp_q[8] - stamp_q[7]) : 32'hFFFF_FFFF, 32'd1);
    check("t4_err", 32'(err), 32'd1);

    // flickering empty flag
    load(1, 8'h11, 8'h11, 4);
    underflow = 0;
    tog_en = 1'b1;
    ch_mask = 8'h02; dev_info = 8'h01; dev_kind = 8'h01; dev_smpr = 8'h01; adc_end = 8'h77;
    exp_q = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAD, 8'h77};
    run_packet("t5");
    tog_en = 1'b0;
    check("t5_underflow", 32'(underflow), 32'd0);
    check("t5_err_cleared", 32'(err), 32'd0);

    // reset mid-READ, then a clean packet
    load(0, 8'h61, 8'h01, 4);
    ch_mask = 8'h01;
    got_q.delete();
    @(negedge clk);
    fs_fifo = 1'b1;
    n = 0;
    while (dbg_state != 3'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_read", 32'(dbg_state), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    fs_fifo = 1'b0;
    @(negedge clk);
    check("t6_rst_txen", 32'(fifod_txen), 32'd0);
    check("t6_rst_txd", 32'(fifod_txd), 32'd0);
    check("t6_rst_rxen", 32'(fifoi_rxen), 32'd0);
    check("t6_rst_fd", 32'(fd_fifo), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    wp[0] = rp[0];
    repeat (2) @(negedge clk);
    load(0, 8'hD1, 8'h01, 4);
    ch_mask = 8'h01; dev_info = 8'h00; dev_kind = 8'h00; dev_smpr = 8'h00; adc_end = 8'h33;
    exp_q = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h4A, 8'h33};
    run_packet("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
